// File: rtl/gcd_arbiter.sv
// Round-robin arbiter sharing one two-phase req/ack gcd engine between NREQ
// four-phase requesters; zero operands bypass the engine.
module gcd_arbiter #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned W    = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ*W-1:0] a,
   input  logic [NREQ*W-1:0] b,
   output logic [NREQ-1:0]   ack,
   output logic [W-1:0]      res,
   output logic              busy,
   output logic [2:0]        gnt_id,
   output logic              gcd_req,
   output logic [W-1:0]      gcd_ab,
   input  logic              gcd_ack,
   input  logic [W-1:0]      gcd_c
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_ZERO   = 3'd1;
   localparam logic [2:0] S_SEND_A = 3'd2;
   localparam logic [2:0] S_DROP_A = 3'd3;
   localparam logic [2:0] S_SEND_B = 3'd4;
   localparam logic [2:0] S_DROP_B = 3'd5;
   localparam logic [2:0] S_RESP   = 3'd6;

   logic [2:0]      state_q, state_d;
   logic [2:0]      rr_q, rr_d;
   logic [2:0]      gnt_q, gnt_d;
   logic [NREQ-1:0] served_q, served_d;
   logic [NREQ-1:0] ack_q, ack_d;
   logic [W-1:0]    opa_q, opa_d, opb_q, opb_d;
   logic [W-1:0]    res_q, res_d, gcd_ab_q, gcd_ab_d;
   logic            gcd_req_q, gcd_req_d, busy_q, busy_d;

   logic            grant;
   logic [2:0]      gidx;
   logic [NREQ-1:0] grant_oh, gnt_oh, eligible;
   logic [W-1:0]    sel_a, sel_b;
   logic            req_gnt;
   int unsigned     cand;

   // A requester already served stays ineligible until it drops req.
   assign eligible = req & ~served_q;

   always_comb begin
      grant    = 1'b0;
      gidx     = '0;
      grant_oh = '0;
      sel_a    = '0;
      sel_b    = '0;
      cand     = 0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         cand = 32'(rr_q) + 1 + k;
         if (cand >= NREQ) cand = cand - NREQ;
         for (int unsigned i = 0; i < NREQ; i++) begin
            if (!grant && i == cand && eligible[i]) begin
               grant       = 1'b1;
               gidx        = 3'(i);
               grant_oh[i] = 1'b1;
               sel_a       = a[i*W +: W];
               sel_b       = b[i*W +: W];
            end
         end
      end
   end

   always_comb begin
      gnt_oh  = '0;
      req_gnt = 1'b0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (3'(i) == gnt_q) begin
            gnt_oh[i] = 1'b1;
            req_gnt   = req[i];
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      rr_d      = rr_q;
      gnt_d     = gnt_q;
      served_d  = served_q & req;
      ack_d     = ack_q;
      opa_d     = opa_q;
      opb_d     = opb_q;
      res_d     = res_q;
      gcd_req_d = gcd_req_q;
      gcd_ab_d  = gcd_ab_q;
      case (state_q)
         S_IDLE: begin
            if (grant) begin
               gnt_d    = gidx;
               rr_d     = gidx;
               opa_d    = sel_a;
               opb_d    = sel_b;
               served_d = served_d | grant_oh;
               if (sel_a == '0 || sel_b == '0) begin
                  state_d = S_ZERO;
               end else begin
                  state_d   = S_SEND_A;
                  gcd_req_d = 1'b1;
                  gcd_ab_d  = sel_a;
               end
            end
         end
         S_ZERO: begin
            res_d   = opa_q | opb_q;
            ack_d   = gnt_oh;
            state_d = S_RESP;
         end
         S_SEND_A: if (gcd_ack) begin
            gcd_req_d = 1'b0;
            state_d   = S_DROP_A;
         end
         S_DROP_A: if (!gcd_ack) begin
            gcd_req_d = 1'b1;
            gcd_ab_d  = opb_q;
            state_d   = S_SEND_B;
         end
         S_SEND_B: if (gcd_ack) begin
            res_d     = gcd_c;
            gcd_req_d = 1'b0;
            state_d   = S_DROP_B;
         end
         S_DROP_B: if (!gcd_ack) begin
            ack_d   = gnt_oh;
            state_d = S_RESP;
         end
         S_RESP: if (!req_gnt) begin
            ack_d   = '0;
            gnt_d   = '0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         rr_q      <= 3'(NREQ - 1);
         gnt_q     <= '0;
         served_q  <= '0;
         ack_q     <= '0;
         opa_q     <= '0;
         opb_q     <= '0;
         res_q     <= '0;
         gcd_req_q <= 1'b0;
         gcd_ab_q  <= '0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         rr_q      <= rr_d;
         gnt_q     <= gnt_d;
         served_q  <= served_d;
         ack_q     <= ack_d;
         opa_q     <= opa_d;
         opb_q     <= opb_d;
         res_q     <= res_d;
         gcd_req_q <= gcd_req_d;
         gcd_ab_q  <= gcd_ab_d;
         busy_q    <= busy_d;
      end
   end

   assign ack     = ack_q;
   assign res     = res_q;
   assign busy    = busy_q;
   assign gnt_id  = gnt_q;
   assign gcd_req = gcd_req_q;
   assign gcd_ab  = gcd_ab_q;

endmodule

// File: tb/tb_gcd_arbiter.sv
// Directed bench for gcd_arbiter with a behavioural two-phase gcd engine.
module tb_gcd_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  req;
   logic [63:0] a, b;
   logic [3:0]  ack;
   logic [15:0] res;
   logic        busy;
   logic [2:0]  gnt_id;
   logic        gcd_req;
   logic [15:0] gcd_ab;
   logic        gcd_ack;
   logic [15:0] gcd_c;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   gcd_arbiter #(.NREQ(4), .W(16)) dut (
      .clk(clk), .reset(reset), .req(req), .a(a), .b(b),
      .ack(ack), .res(res), .busy(busy), .gnt_id(gnt_id),
      .gcd_req(gcd_req), .gcd_ab(gcd_ab), .gcd_ack(gcd_ack), .gcd_c(gcd_c)
   );

   function automatic logic [15:0] gcd_fn(input logic [15:0] x, input logic [15:0] y);
      logic [15:0] p, q, t;
      p = x; q = y;
      while (q != 0) begin
         t = p % q; p = q; q = t;
      end
      return p;
   endfunction

   // Engine model: waitA, dropA, waitB, compute, fin
   logic [2:0]  est;
   logic [15:0] ea, eb, ec, last_a, last_b;
   int          ecnt;
   int          loads = 0;
   int          zero_in = 0;
   int          onehot_viol = 0;

   always @(posedge clk) begin
      if (reset) begin
         est <= 0; gcd_ack <= 1'b0; ecnt <= 0;
      end else begin
         case (est)
            0: if (gcd_req) begin
               ea <= gcd_ab; last_a <= gcd_ab; gcd_ack <= 1'b1; est <= 1;
               loads <= loads + 1;
               if (gcd_ab == 0) zero_in <= zero_in + 1;
            end
            1: if (!gcd_req) begin gcd_ack <= 1'b0; est <= 2; end
            2: if (gcd_req) begin
               eb <= gcd_ab; last_b <= gcd_ab; ecnt <= 3; est <= 3;
               if (gcd_ab == 0) zero_in <= zero_in + 1;
            end
            3: if (ecnt == 0) begin
               ec <= gcd_fn(ea, eb); gcd_ack <= 1'b1; est <= 4;
            end else ecnt <= ecnt - 1;
            default: if (!gcd_req) begin gcd_ack <= 1'b0; est <= 0; end
         endcase
      end
   end

   assign gcd_c = (est == 4) ? ec : 16'hDEAD;

   always @(negedge clk) if (!$onehot0(ack)) onehot_viol++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic wait_ack(output int cyc);
      cyc = 0;
      do begin @(negedge clk); cyc++; end while (ack == 0 && cyc < 300);
      if (ack == 0) begin
         checks++; errors++;
         $display("FAIL ack_timeout: got ack=0 expected nonzero within 300 cycles");
      end
   endtask

   task automatic wait_ack_low();
      int cyc = 0;
      do begin @(negedge clk); cyc++; end while (ack != 0 && cyc < 50);
      if (ack != 0) begin
         checks++; errors++;
         $display("FAIL ack_release: got ack=%0d expected 0", ack);
      end
   endtask

   task automatic set_ops(input int idx, input logic [15:0] av, input logic [15:0] bv);
      a[idx*16 +: 16] = av;
      b[idx*16 +: 16] = bv;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   // One isolated transaction on requester idx; returns cycles from req to ack.
   task automatic serve(input int idx, input logic [15:0] av, input logic [15:0] bv,
                        input logic [15:0] exp, output int cyc);
      set_ops(idx, av, bv);
      req[idx] = 1'b1;
      wait_ack(cyc);
      check("ack_onehot", 32'(ack), 32'(4'b0001 << idx));
      check("res", 32'(res), 32'(exp));
      check("gnt_id", 32'(gnt_id), 32'(idx));
      check("busy_resp", 32'(busy), 1);
      req[idx] = 1'b0;
      wait_ack_low();
      check("busy_idle", 32'(busy), 0);
      check("gnt_id_idle", 32'(gnt_id), 0);
   endtask

   typedef struct {
      int          idx;
      logic [15:0] va;
      logic [15:0] vb;
      logic [15:0] exp;
      bit          zero;
   } vec_t;

   vec_t tbl[8];

   initial begin
      int cyc, l0;
      tbl[0] = '{0, 16'd48,    16'd18,    16'd6,     1'b0};
      tbl[1] = '{1, 16'd0,     16'd9,     16'd9,     1'b1};
      tbl[2] = '{2, 16'd0,     16'd0,     16'd0,     1'b1};
      tbl[3] = '{3, 16'd65535, 16'd65535, 16'd65535, 1'b0};
      tbl[4] = '{0, 16'd65521, 16'd1,     16'd1,     1'b0};
      tbl[5] = '{2, 16'd9,     16'd0,     16'd9,     1'b1};
      tbl[6] = '{1, 16'd35,    16'd21,    16'd7,     1'b0};
      tbl[7] = '{3, 16'd1071,  16'd462,   16'd21,    1'b0};

      req = '0; a = '0; b = '0; reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      check("rst_ack", 32'(ack), 0);
      check("rst_res", 32'(res), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_gnt", 32'(gnt_id), 0);
      check("rst_gcd_req", 32'(gcd_req), 0);
      check("rst_gcd_ab", 32'(gcd_ab), 0);

      foreach (tbl[n]) begin
         l0 = loads;
         serve(tbl[n].idx, tbl[n].va, tbl[n].vb, tbl[n].exp, cyc);
         if (tbl[n].zero) begin
            check("zero_no_engine", 32'(loads - l0), 0);
            check("zero_latency", 32'(cyc), 2);
         end else begin
            check("engine_loads", 32'(loads - l0), 1);
            check("engine_a", 32'(last_a), 32'(tbl[n].va));
            check("engine_b", 32'(last_b), 32'(tbl[n].vb));
         end
      end

      // Contention from reset: pointer starts at NREQ-1, so order is 0,1,2,3
      do_reset();
      for (int i = 0; i < 4; i++) set_ops(i, 16'd35, 16'd21);
      req = 4'b1111;
      for (int k = 0; k < 4; k++) begin
         wait_ack(cyc);
         check("cont_ack", 32'(ack), 32'(4'b0001 << k));
         check("cont_res", 32'(res), 7);
         check("cont_gnt", 32'(gnt_id), 32'(k));
         req[k] = 1'b0;
         wait_ack_low();
      end

      // Fairness wrap: after 2 is served, 3 precedes 1
      serve(2, 16'd12, 16'd8, 16'd4, cyc);
      set_ops(1, 16'd100, 16'd75);
      set_ops(3, 16'd81, 16'd27);
      req[1] = 1'b1; req[3] = 1'b1;
      wait_ack(cyc);
      check("wrap_first", 32'(ack), 32'(4'b1000));
      check("wrap_first_res", 32'(res), 27);
      req[3] = 1'b0;
      wait_ack_low();
      wait_ack(cyc);
      check("wrap_second", 32'(ack), 32'(4'b0010));
      check("wrap_second_res", 32'(res), 25);
      req[1] = 1'b0;
      wait_ack_low();

      // Reset while the engine is computing on operand B
      set_ops(0, 16'd48, 16'd18);
      req[0] = 1'b1;
      cyc = 0;
      do begin @(negedge clk); cyc++; end
      while (!(est == 3 && gcd_req && gcd_ab == 16'd18) && cyc < 100);
      check("reach_send_b", 32'(est == 3 && gcd_req), 1);
      reset = 1'b1;
      @(negedge clk);
      check("midrst_busy", 32'(busy), 0);
      check("midrst_ack", 32'(ack), 0);
      check("midrst_gcd_req", 32'(gcd_req), 0);
      reset = 1'b0;
      wait_ack(cyc);
      check("post_rst_ack", 32'(ack), 1);
      check("post_rst_res", 32'(res), 6);
      check("post_rst_gnt", 32'(gnt_id), 0);
      req[0] = 1'b0;
      wait_ack_low();

      check("engine_zero_operands", 32'(zero_in), 0);
      check("ack_onehot_monitor", 32'(onehot_viol), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
